// File: rtl/approx_mul_seq_ctrl_if.sv
// Operand/product handshake bundle for the radix-4 approximate multiplier controller.
// master = operand source and product sink, slave = controller.
interface approx_mul_seq_ctrl_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/approx_mul_seq_ctrl.sv
// Sequencing controller: unsigned NxN multiply as N/2 radix-4 digit steps through the partial-product mux.
// Optional low-digit truncation is enabled by defining APPROX_TRUNC_EN.
module approx_mul_seq_ctrl #(
    parameter int N            = 8,
    parameter int TRUNC_DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    approx_mul_seq_ctrl_if.slave  bus,
    output logic                  busy
);
    localparam int W  = 2 * N;
    localparam int KW = $clog2(N / 2 + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);

`ifdef APPROX_TRUNC_EN
    localparam int TRUNC_K = TRUNC_DIGITS;
`else
    // Exact build: truncation threshold pinned to zero so no digit is ever dropped.
    localparam int TRUNC_K = TRUNC_DIGITS * 0;
`endif

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [W-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [KW-1:0] k;

    logic [1:0]    sel;
    logic [W-1:0]  mux_x;
    logic [W-1:0]  mux_y;
    logic [W-1:0]  mux_r;

    // Bit-mask-select partial-product mux; code 10 is never issued and yields zero.
    function automatic logic [W-1:0] pp_mux(input logic [1:0] s,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (s)
            2'b01:   return x;
            2'b11:   return x + y;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        sel   = 2'b00;
        mux_x = '0;
        mux_y = '0;
        case (b_sh[1:0])
            2'd1: begin
                sel   = 2'b01;
                mux_x = a_sh;
            end
            2'd2: begin
                sel   = 2'b01;
                mux_x = a_sh << 1;
            end
            2'd3: begin
                sel   = 2'b11;
                mux_x = a_sh;
                mux_y = a_sh << 1;
            end
            default: ;
        endcase
        if (int'(k) < TRUNC_K) sel = 2'b00;
    end

    assign mux_r = pp_mux(sel, mux_x, mux_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= {{N{1'b0}}, bus.in_a};
                        b_sh  <= bus.in_b;
                        acc   <= '0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                // One radix-4 digit retired per edge; the step count is data independent.
                RUN: begin
                    acc  <= acc + mux_r;
                    a_sh <= a_sh << 2;
                    b_sh <= b_sh >> 2;
                    k    <= k + KW'(1);
                    if (k == K_LAST) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_p     = acc;
    assign busy          = (state == RUN) || (state == DONE);
endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// Scoreboard bench for approx_mul_seq_ctrl: driver pushes expected products, a monitor pops on each handshake.
// Define APPROX_TRUNC_EN for both bench and RTL to exercise the truncated build.
module tb_approx_mul_seq_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    approx_mul_seq_ctrl_if #(.N(N)) bus ();

    approx_mul_seq_ctrl #(.N(N), .TRUNC_DIGITS(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          sel_bad   = 0;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic        prev_valid = 1'b0;
    bit          stall_mode = 1'b0;
    bit          hold_low   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef APPROX_TRUNC_EN
        return 16'(a) * 16'(b & 8'hFC);
`else
        return 16'(a) * 16'(b);
`endif
    endfunction

    // Sink back-pressure: random stalls in sweep mode, forced low on request, else always ready.
    always @(posedge clk) begin
        #2;
        if (stall_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
        else            bus.out_ready = !hold_low;
    end

    // Monitor: latency on each rising out_valid, product on each output handshake.
    always @(negedge clk) begin
        if (busy && dut.sel == 2'b10) sel_bad++;
        if (!rst) begin
            if (bus.out_valid && !prev_valid) begin
                if (acc_q.size() == 0) fail_now("spurious_out_valid");
                else check("latency", 32'(cyc - acc_q.pop_front()), 32'd4);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_product");
                else check("product", 32'(bus.out_p), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_p", 32'(bus.out_p), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef APPROX_TRUNC_EN
        send(8'h00, 8'hFF, 16'h0000);
        send(8'hFF, 8'hFF, 16'hFE01);
        send(8'h03, 8'h03, 16'h0009);
        send(8'h0A, 8'h02, 16'h0014);
        drain();

        // Back-pressure with a competing in_valid held high throughout.
        @(posedge clk);
        #1;
        hold_low = 1'b1;
        send(8'h0F, 8'h0F, 16'h00E1);
        @(posedge clk);
        #1;
        bus.in_a     = 8'h02;
        bus.in_b     = 8'h03;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("bp_valid_timeout");
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_p", 32'(bus.out_p), 32'h00E1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        send(8'h02, 8'h03, 16'h0006);
        drain();

        // Abort in the second RUN cycle.
        send(8'hFF, 8'hFF, 16'hFE01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_p", 32'(bus.out_p), 32'd0);
        repeat (8) @(negedge clk);
        send(8'h12, 8'h34, 16'h03A8);
        drain();
`else
        send(8'h10, 8'h07, 16'h0040);
        send(8'h10, 8'h03, 16'h0000);
        send(8'hFF, 8'hFF, 16'hFB04);
        drain();
`endif

        stall_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, model(ra, rb));
        end
        drain();
        stall_mode = 1'b0;
        check("no_sel_10", 32'(sel_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
